// File: rtl/check_stream_pkg.sv
// Shared definitions for the property checker's result stream: verdict characters,
// transmitter state encoding and a saturating counter helper.
package check_stream_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CHAR_PASS = 8'h50;
  localparam logic [BYTE_W-1:0] CHAR_FAIL = 8'h46;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer for the result UART: counts 0..CLKS_PER_BIT-1 while run is high
// and flags the last cycle of each bit period.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic bit_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_done = run && (cnt_q == LAST);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = bit_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/check_result_uart_tx.sv
// Result-stream sink: pops verdict bytes, sends each as an 8N1 UART frame and keeps
// sticky pass/fail LED flags. Define CHECK_RESULT_STATUS_EN to build the verdict decoder.
module check_result_uart_tx
  import check_stream_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_canPeek,
  input  logic [BYTE_W-1:0] in_peek,
  output logic              in_consume_en,
  output logic              uart_tx,
  output logic              busy,
  output logic              pass_seen,
  output logic              fail_seen,
  output logic [15:0]       byte_count
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("check_result_uart_tx: CLKS_PER_BIT must be >= 2");
  end

  tx_state_t         state_q, state_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic              tx_q, tx_d;
  logic [15:0]       byte_count_q, byte_count_d;
  logic              consume;
  logic              bit_done;

  // Gated by reset so the pop strobe stays low while reset is held.
  assign consume       = reset && (state_q == IDLE) && in_canPeek;
  assign in_consume_en = consume;
  assign uart_tx       = tx_q;
  assign busy          = (state_q != IDLE);
  assign byte_count    = byte_count_q;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clock   (clock),
    .reset   (reset),
    .clear   (consume),
    .run     (state_q != IDLE),
    .bit_done(bit_done)
  );

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_idx_d    = bit_idx_q;
    byte_count_d = byte_count_q;
    tx_d         = 1'b1;
    case (state_q)
      IDLE: if (consume) begin
        state_d      = START;
        shift_d      = in_peek;
        byte_count_d = sat_inc16(byte_count_q);
      end
      START: if (bit_done) begin
        state_d   = DATA;
        bit_idx_d = '0;
      end
      DATA: if (bit_done) begin
        shift_d   = {1'b0, shift_q[BYTE_W-1:1]};
        bit_idx_d = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) state_d = STOP;
      end
      STOP: if (bit_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The line is driven from the next state so it is registered yet aligned with it.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      // NOTE: the shift register is reset too; it is a handful of flops, not a memory array.
      shift_q      <= '0;
      bit_idx_q    <= '0;
      tx_q         <= 1'b1;
      byte_count_q <= '0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_idx_q    <= bit_idx_d;
      tx_q         <= tx_d;
      byte_count_q <= byte_count_d;
    end
  end

`ifdef CHECK_RESULT_STATUS_EN
  logic pass_q, pass_d;
  logic fail_q, fail_d;

  always_comb begin
    pass_d = pass_q;
    fail_d = fail_q;
    if (consume) begin
      if (in_peek == CHAR_PASS) pass_d = 1'b1;
      if (in_peek == CHAR_FAIL) fail_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end

  assign pass_seen = pass_q;
  assign fail_seen = fail_q;
`else
  assign pass_seen = 1'b0;
  assign fail_seen = 1'b0;
`endif

endmodule
